// File: rtl/str_pkg.sv
// Shared types and constants for the print-string syscall engine.
package str_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    EMIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int unsigned SYSCALL_PRINT_STRING = 4;
  localparam int unsigned BYTE_W               = 8;
  localparam int unsigned WORD_W               = 32;

endpackage

// File: rtl/byte_select.sv
// Picks one little-endian byte out of a 32-bit memory word.
module byte_select
  import str_pkg::*;
(
  input  logic [WORD_W-1:0] word,
  input  logic [1:0]        offset,
  output logic [BYTE_W-1:0] sel_byte_c
);

  always_comb begin
    sel_byte_c = word[7:0];
    case (offset)
      2'd0:    sel_byte_c = word[7:0];
      2'd1:    sel_byte_c = word[15:8];
      2'd2:    sel_byte_c = word[23:16];
      default: sel_byte_c = word[31:24];
    endcase
  end

endmodule

// File: rtl/string_reader.sv
// Print-string engine: fetches words of a null-terminated string from data
// memory and hands out one character per valid/ready handshake.
module string_reader
  import str_pkg::*;
#(
  parameter int unsigned MAX_LEN = 256,
  parameter int unsigned LEN_W   = 9
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [31:0]       str_addr,
  output logic              mem_read,
  output logic [31:0]       mem_address,
  input  logic [31:0]       mem_read_data,
  output logic [7:0]        char_out,
  output logic              char_valid,
  input  logic              char_ready,
  output logic              busy,
  output logic              done,
  output logic              truncated,
  output logic [LEN_W-1:0]  length
);

  state_t            state;
  logic [31:0]       ptr;
  logic [31:0]       word;
  logic [LEN_W-1:0]  count;

  logic [31:0]       ptr_inc;
  logic [LEN_W-1:0]  count_inc;
  logic [31:0]       sel_word;
  logic [1:0]        sel_off;
  logic [7:0]        sel_byte_c;

  assign ptr_inc   = ptr + 32'd1;
  assign count_inc = count + LEN_W'(1);

  // In FETCH the first byte comes straight from memory; in EMIT it is the next byte of the held word.
  always_comb begin
    sel_word = word;
    sel_off  = ptr_inc[1:0];
    if (state == FETCH) begin
      sel_word = mem_read_data;
      sel_off  = ptr[1:0];
    end
  end

  byte_select u_byte_select (
    .word       (sel_word),
    .offset     (sel_off),
    .sel_byte_c (sel_byte_c)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      ptr         <= '0;
      word        <= '0;
      count       <= '0;
      mem_read    <= 1'b0;
      mem_address <= '0;
      char_out    <= '0;
      char_valid  <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      truncated   <= 1'b0;
      length      <= '0;
    end else begin
      done     <= 1'b0;
      mem_read <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            ptr         <= str_addr;
            count       <= '0;
            mem_read    <= 1'b1;
            mem_address <= {str_addr[31:2], 2'b00};
            busy        <= 1'b1;
            state       <= FETCH;
          end
        end
        FETCH: begin
          word       <= mem_read_data;
          char_out   <= sel_byte_c;
          char_valid <= (sel_byte_c != 8'd0);
          state      <= EMIT;
        end
        EMIT: begin
          if (!char_valid) begin
            // Current byte is the terminator: finish without emitting it.
            state     <= DONE;
            done      <= 1'b1;
            busy      <= 1'b0;
            truncated <= 1'b0;
            length    <= count;
          end else if (char_ready) begin
            count <= count_inc;
            ptr   <= ptr_inc;
            if (count_inc == LEN_W'(MAX_LEN)) begin
              state      <= DONE;
              done       <= 1'b1;
              busy       <= 1'b0;
              truncated  <= 1'b1;
              length     <= count_inc;
              char_valid <= 1'b0;
            end else if (ptr[1:0] == 2'd3) begin
              state       <= FETCH;
              mem_read    <= 1'b1;
              mem_address <= {ptr_inc[31:2], 2'b00};
              char_valid  <= 1'b0;
            end else begin
              char_out   <= sel_byte_c;
              char_valid <= (sel_byte_c != 8'd0);
            end
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_string_reader.sv
// Self-checking bench for string_reader: directed vector table, reset abort
// sequence and random strings compared against a byte-level string model.
module tb_string_reader;
  import str_pkg::*;

  localparam int unsigned LEN_W = 9;
  localparam logic [31:0] BASE  = 32'h7FFF_FC00;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [7:0]  mem [0:1023];
  logic        sel;
  logic        start, char_ready;
  logic [31:0] str_addr;
  logic        start_a, start_b;

  logic             mr_a, mr_b, cv_a, cv_b, busy_a, busy_b, done_a, done_b, tr_a, tr_b;
  logic [31:0]      ma_a, ma_b, md_a, md_b;
  logic [7:0]       co_a, co_b;
  logic [LEN_W-1:0] len_a, len_b;

  logic             m_mr, m_cv, m_busy, m_done, m_tr;
  logic [31:0]      m_ma;
  logic [7:0]       m_co;
  logic [LEN_W-1:0] m_len;

  assign start_a = start & ~sel;
  assign start_b = start & sel;

  assign md_a = {mem[{ma_a[9:2], 2'd3}], mem[{ma_a[9:2], 2'd2}], mem[{ma_a[9:2], 2'd1}], mem[{ma_a[9:2], 2'd0}]};
  assign md_b = {mem[{ma_b[9:2], 2'd3}], mem[{ma_b[9:2], 2'd2}], mem[{ma_b[9:2], 2'd1}], mem[{ma_b[9:2], 2'd0}]};

  string_reader #(.MAX_LEN(256), .LEN_W(LEN_W)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .str_addr(str_addr),
    .mem_read(mr_a), .mem_address(ma_a), .mem_read_data(md_a),
    .char_out(co_a), .char_valid(cv_a), .char_ready(char_ready),
    .busy(busy_a), .done(done_a), .truncated(tr_a), .length(len_a)
  );

  string_reader #(.MAX_LEN(4), .LEN_W(LEN_W)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .str_addr(str_addr),
    .mem_read(mr_b), .mem_address(ma_b), .mem_read_data(md_b),
    .char_out(co_b), .char_valid(cv_b), .char_ready(char_ready),
    .busy(busy_b), .done(done_b), .truncated(tr_b), .length(len_b)
  );

  assign m_mr   = sel ? mr_b   : mr_a;
  assign m_ma   = sel ? ma_b   : ma_a;
  assign m_cv   = sel ? cv_b   : cv_a;
  assign m_co   = sel ? co_b   : co_a;
  assign m_busy = sel ? busy_b : busy_a;
  assign m_done = sel ? done_b : done_a;
  assign m_tr   = sel ? tr_b   : tr_a;
  assign m_len  = sel ? len_b  : len_a;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual=%0h expected=%0h (t=%0t)", nm, act, exp, $time);
  endtask

  // Observation state filled by the negedge monitor.
  int               cyc = 0;
  int               c0, first_v_at, done_at, done_cnt;
  logic [LEN_W-1:0] done_len;
  logic             done_tr;
  logic [7:0]       got_q[$];
  logic [31:0]      fetch_q[$];
  logic [7:0]       exp_q[$];
  logic             hold_prev = 1'b0;
  logic [7:0]       prev_co;

  always @(negedge clk) begin
    cyc = cyc + 1;
    if (!rst_n) begin
      hold_prev = 1'b0;
    end else begin
      if (hold_prev) begin
        chk("hold_valid", 64'(m_cv), 64'd1);
        chk("hold_char", 64'(m_co), 64'(prev_co));
      end
      hold_prev = m_cv && !char_ready;
      prev_co   = m_co;
      if (m_mr) begin
        fetch_q.push_back(m_ma);
        chk("addr_align", 64'(m_ma[1:0]), 64'd0);
      end
      if (m_cv && first_v_at < 0) first_v_at = cyc;
      if (m_cv && char_ready) got_q.push_back(m_co);
      if (m_done) begin
        done_cnt++;
        done_at  = cyc;
        done_len = m_len;
        done_tr  = m_tr;
        chk("busy_at_done", 64'(m_busy), 64'd0);
      end
    end
  end

  task automatic put_word(input logic [31:0] a, input logic [31:0] w);
    for (int k = 0; k < 4; k++) mem[10'({a[9:2], 2'b00}) + 10'(k)] = w[8*k +: 8];
  endtask

  // rmode: 0 = ready always high, 1 = random ready, 2 = ready low for 5 cycles after first char.
  task automatic run(input logic s, input logic [31:0] a, input int rmode);
    int k;
    got_q.delete();
    fetch_q.delete();
    done_cnt   = 0;
    first_v_at = -1;
    done_at    = -1;
    sel        = s;
    str_addr   = a;
    start      = 1'b1;
    char_ready = (rmode == 1) ? ($urandom_range(0, 3) != 0) : 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    c0    = cyc;
    k     = 0;
    while (done_cnt == 0 && k < 3000) begin
      @(posedge clk); #1;
      k++;
      case (rmode)
        1:       char_ready = ($urandom_range(0, 3) != 0);
        2:       char_ready = !(k >= 2 && k <= 6);
        default: char_ready = 1'b1;
      endcase
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic compare(input logic exp_tr, input logic [31:0] a, input int exp_fetch);
    chk("done_count", 64'(done_cnt), 64'd1);
    chk("length", 64'(done_len), 64'(exp_q.size()));
    chk("truncated", 64'(done_tr), 64'(exp_tr));
    chk("char_count", 64'(got_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      chk("char", 64'(got_q[i]), 64'(exp_q[i]));
    chk("fetch_count", 64'(fetch_q.size()), 64'(exp_fetch));
    for (int i = 0; i < fetch_q.size() && i < exp_fetch; i++)
      chk("fetch_addr", 64'(fetch_q[i]), 64'({a[31:2], 2'b00} + 32'(4 * i)));
    if (exp_q.size() == 0) chk("empty_done_latency", 64'(done_at - c0), 64'd3);
    else                   chk("first_valid_latency", 64'(first_v_at - c0), 64'd2);
  endtask

  // Reference: walk bytes until a null or the length limit, count words touched.
  task automatic model(input logic [31:0] a, input int ml, output logic tr, output int nwords);
    int last;
    logic [7:0] b;
    exp_q.delete();
    tr   = 1'b0;
    last = 0;
    for (int i = 0; i < 4096; i++) begin
      b = mem[10'(a + 32'(i))];
      if (b == 8'd0) begin last = i; break; end
      exp_q.push_back(b);
      if (exp_q.size() == ml) begin tr = 1'b1; last = i; break; end
    end
    nwords = int'((a + 32'(last)) >> 2) - int'(a >> 2) + 1;
  endtask

  typedef struct {
    logic        s;
    logic [31:0] addr;
    logic [31:0] w0, w1, w2;
    int          rmode;
    int          exp_len;
    logic        exp_tr;
    logic [63:0] exp_chars;
    int          exp_fetch;
  } vec_t;

  vec_t vecs[6];

  initial begin
    logic tr;
    int   nw;
    vecs[0] = '{1'b0, BASE + 32'h00, 32'h0021_6948, 32'h0, 32'h0, 0, 3, 1'b0, 64'h21_6948, 1};
    vecs[1] = '{1'b0, BASE + 32'h02, 32'h6362_AAAA, 32'h0000_6564, 32'h0, 0, 4, 1'b0, 64'h6564_6362, 2};
    vecs[2] = '{1'b0, BASE + 32'h10, 32'h4142_4300, 32'h0, 32'h0, 0, 0, 1'b0, 64'h0, 1};
    vecs[3] = '{1'b1, BASE + 32'h20, 32'h4443_4241, 32'h0047_4645, 32'h0, 0, 4, 1'b1, 64'h4443_4241, 1};
    vecs[4] = '{1'b0, BASE + 32'h40, 32'h6463_6261, 32'h0067_6665, 32'h0, 2, 7, 1'b0, 64'h67_6665_6463_6261, 2};
    vecs[5] = '{1'b1, BASE + 32'h31, 32'h4342_4199, 32'h0046_4544, 32'h0, 0, 4, 1'b1, 64'h4443_4241, 2};

    for (int i = 0; i < 1024; i++) mem[i] = 8'hAA;
    rst_n = 1'b0; start = 1'b0; sel = 1'b0; str_addr = '0; char_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_mem_read", 64'(mr_a), 64'd0);
    chk("rst_mem_address", 64'(ma_a), 64'd0);
    chk("rst_char_out", 64'(co_a), 64'd0);
    chk("rst_char_valid", 64'(cv_a), 64'd0);
    chk("rst_busy", 64'(busy_a), 64'd0);
    chk("rst_done", 64'(done_a), 64'd0);
    chk("rst_truncated", 64'(tr_a), 64'd0);
    chk("rst_length", 64'(len_a), 64'd0);
    chk("rst_busy_b", 64'(busy_b), 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int v = 0; v < 6; v++) begin
      for (int i = 0; i < 1024; i++) mem[i] = 8'hAA;
      put_word(vecs[v].addr, vecs[v].w0);
      put_word(vecs[v].addr + 32'd4, vecs[v].w1);
      put_word(vecs[v].addr + 32'd8, vecs[v].w2);
      exp_q.delete();
      for (int i = 0; i < vecs[v].exp_len; i++) exp_q.push_back(vecs[v].exp_chars[8*i +: 8]);
      run(vecs[v].s, vecs[v].addr, vecs[v].rmode);
      compare(vecs[v].exp_tr, vecs[v].addr, vecs[v].exp_fetch);
    end

    // Reset while a character is waiting for the sink, then reprint.
    for (int i = 0; i < 1024; i++) mem[i] = 8'hAA;
    put_word(BASE + 32'h80, 32'h7A79_7877);
    put_word(BASE + 32'h84, 32'h0000_0031);
    sel = 1'b0; str_addr = BASE + 32'h80; char_ready = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    chk("pre_reset_valid", 64'(cv_a), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("reset_busy", 64'(busy_a), 64'd0);
    chk("reset_char_valid", 64'(cv_a), 64'd0);
    chk("reset_mem_read", 64'(mr_a), 64'd0);
    chk("reset_done", 64'(done_a), 64'd0);
    @(posedge clk); #1;
    chk("reset_done_held", 64'(done_a), 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    model(BASE + 32'h80, 256, tr, nw);
    run(1'b0, BASE + 32'h80, 0);
    compare(tr, BASE + 32'h80, nw);

    // Random strings against the model.
    for (int t = 0; t < 40; t++) begin
      logic        s;
      logic [31:0] a;
      for (int i = 0; i < 1024; i++)
        mem[i] = ($urandom_range(0, 24) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
      s = 1'($urandom_range(0, 1));
      a = BASE + 32'($urandom_range(0, 400));
      model(a, s ? 4 : 256, tr, nw);
      run(s, a, int'($urandom_range(0, 1)));
      compare(tr, a, nw);
    end

    // Unterminated string hits the full 256-character limit.
    for (int i = 0; i < 1024; i++) mem[i] = 8'($urandom_range(1, 255));
    model(BASE + 32'd3, 256, tr, nw);
    run(1'b0, BASE + 32'd3, 1);
    compare(tr, BASE + 32'd3, nw);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
